cpu_machine_ctl: RTL and testbench
==================================

Name: cpu_machine_ctl

Overview:
- Instruction-cycle controller of the 8-bit accumulator CPU (13-bit address, 8-bit bidirectional data bus, 3-bit opcode).
- Sits directly upstream of the datapath: instruction register, program counter, accumulator, data-bus driver, and the `rd`/`wr`/`halt` pins.
- Sequences an 8-cycle fetch/execute loop.
- Decodes the current `opcode` and the accumulator `zero` flag into registered one-hot-ish control strobes.

Parameters:
- OP_HLT, 3'b000, halt
- OP_SKZ, 3'b001, skip next instruction if accumulator zero
- OP_ADD, 3'b010, acc <= acc + mem
- OP_AND, 3'b011, acc <= acc & mem
- OP_XOR, 3'b100, acc <= acc ^ mem
- OP_LDA, 3'b101, acc <= mem
- OP_STO, 3'b110, mem <= acc
- OP_JMP, 3'b111, pc <= ir_addr

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- ena  input  1  run enable; low forces the idle start condition
- opcode  input  3  opcode field from the instruction register
- zero  input  1  accumulator == 0 flag
- inc_pc  output  1  PC increment strobe
- load_pc  output  1  PC load from `ir_addr`
- load_acc  output  1  accumulator load from ALU result
- load_ir  output  1  instruction register captures data bus (2 bytes over S0/S1)
- rd  output  1  memory read strobe
- wr  output  1  memory write strobe
- datactl_ena  output  1  enable accumulator onto data bus
- halt  output  1  CPU halted
- state  output  3  current cycle index 0..7, for debug/bench

Behaviour:
- **Reset:** `reset` low → `state`=0, halted flag=0, all strobes and `halt`=0, immediately (asynchronous).
- **Ena low:** with `reset` high and `ena` low, each edge forces `state`=0 and all strobes 0. The halted flag is held, not cleared.
- **Advance:** with `ena` high and not halted, each edge performs state <= state+1 mod 8. In the same edge, outputs <= row(state, opcode, zero). Strobes therefore appear the cycle after the state is entered and last exactly one cycle unless the next row repeats them.
- **Strobe rows** (any strobe not listed is 0):
  - S0: `rd`, `load_ir` (high byte)
  - S1: `rd`, `load_ir`, `inc_pc` (low byte)
  - S2: none
  - S3:
    - HLT → `halt`=1, halted flag set.
    - Other opcodes → `inc_pc`.
  - S4:
    - ADD/AND/XOR/LDA → `rd`
    - JMP → `load_pc`
    - STO → `datactl_ena`
    - SKZ/HLT → none
  - S5:
    - ADD/AND/XOR/LDA → `rd`, `load_acc`
    - SKZ with `zero`=1 → `inc_pc`
    - JMP → `load_pc`, `inc_pc`
    - STO → `datactl_ena`, `wr`
  - S6:
    - ADD/AND/XOR/LDA → `rd`
    - STO → `datactl_ena`
  - S7:
    - SKZ with `zero`=1 → `inc_pc`
    - Otherwise none.
- **Sampling:** `opcode` and `zero` are sampled on each edge; they must be stable from S2 onward. The controller applies no internal latch.
- **Halted:** once the halted flag is set, `state` freezes at 4. `halt` stays 1 and all other strobes are 0 on every edge until `reset` is asserted. `ena` toggling does not release halt.
- **Exclusivity:** `rd` and `wr` are never 1 in the same cycle. `wr`=1 implies `datactl_ena`=1.
- **Reset mid-cycle:** `reset` asserted in any state returns to S0/all-zero asynchronously. The first strobe row after release is S0's, one edge after `reset` deasserts with `ena`=1.
- **Cycle length:** the instruction cycle is always 8 edges; there are no wait states.

Test Plan:
- **Reset/idle:**
  - Stimulus: hold `reset`=0 for 3 edges, then release with `ena`=0 for 4 edges.
  - Required: `state`=0 and all outputs 0 throughout.
  - Then `ena`=1: `rd`=1 and `load_ir`=1 appear after the first edge, and `inc_pc` is added after the second.
- **LDA** (opcode=5, `zero`=0):
  - Required, across one 8-edge cycle: `rd` high for edges 1,2,5,6,7; `load_acc` only on edge 6; `inc_pc` on edges 2 and 4.
  - `wr`, `load_pc` and `halt` stay 0.
- **STO** (opcode=6):
  - Required: `datactl_ena` high for edges 5,6,7; `wr` high only on edge 6; `rd` 0 on edges 5–7.
- **SKZ:**
  - Stimulus: opcode=1, with `zero`=1 on the first cycle and `zero`=0 on the second.
  - Required: first cycle gives `inc_pc` on edges 2,4,6,8 (4 pulses); second cycle gives `inc_pc` on edges 2,4 only.
- **JMP then HLT:**
  - Stimulus: opcode=7 for one cycle, then opcode=0.
  - Required: `load_pc` on edges 5 and 6 of the JMP cycle.
  - On the HLT cycle, `halt` goes 1 on edge 4 and stays 1 for 20 further edges with `state`=4; toggling `ena` has no effect.
  - Then pulse `reset`=0 mid-cycle: `halt`=0 and `state`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_machine_ctl.sv
// Instruction-cycle controller for the 8-bit accumulator CPU.
// Eight-state fetch/execute loop with registered control strobes.
module cpu_machine_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4, S5, S6, S7
  } state_e;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic load_ir;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d, row;
  logic   halted_q, halted_d;
  logic   is_alu, is_skz_z;

  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_skz_z = (opcode == OP_SKZ) && zero;

  always_comb begin
    row = '0;
    unique case (state_q)
      S0: begin
        row.rd      = 1'b1;
        row.load_ir = 1'b1;
      end
      S1: begin
        row.rd      = 1'b1;
        row.load_ir = 1'b1;
        row.inc_pc  = 1'b1;
      end
      S2: ;
      S3: begin
        if (opcode == OP_HLT) row.halt = 1'b1;
        else row.inc_pc = 1'b1;
      end
      S4: begin
        row.rd          = is_alu;
        row.load_pc     = (opcode == OP_JMP);
        row.datactl_ena = (opcode == OP_STO);
      end
      S5: begin
        row.rd          = is_alu;
        row.load_acc    = is_alu;
        row.inc_pc      = is_skz_z || (opcode == OP_JMP);
        row.load_pc     = (opcode == OP_JMP);
        row.datactl_ena = (opcode == OP_STO);
        row.wr          = (opcode == OP_STO);
      end
      S6: begin
        row.rd          = is_alu;
        row.datactl_ena = (opcode == OP_STO);
      end
      S7: row.inc_pc = is_skz_z;
      default: ;
    endcase
  end

  // Halt outranks ena so the CPU cannot be restarted without reset.
  always_comb begin
    state_d  = state_q;
    ctl_d    = '0;
    halted_d = halted_q;
    if (halted_q) begin
      state_d    = S4;
      ctl_d.halt = 1'b1;
    end else if (!ena) begin
      state_d = S0;
    end else begin
      state_d  = state_e'(state_q + 3'd1);
      ctl_d    = row;
      halted_d = row.halt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S0;
      ctl_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      halted_q <= halted_d;
    end
  end

  assign inc_pc      = ctl_q.inc_pc;
  assign load_pc     = ctl_q.load_pc;
  assign load_acc    = ctl_q.load_acc;
  assign load_ir     = ctl_q.load_ir;
  assign rd          = ctl_q.rd;
  assign wr          = ctl_q.wr;
  assign datactl_ena = ctl_q.datactl_ena;
  assign halt        = ctl_q.halt;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_machine_ctl.sv
// Bench for cpu_machine_ctl: behavioural model with per-cycle compare
// plus directed per-instruction strobe patterns.
module tb_cpu_machine_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc, load_pc, load_acc, load_ir;
  logic       rd, wr, datactl_ena, halt;
  logic [2:0] state;

  int total = 0;
  int passed = 0;

  cpu_machine_ctl dut (
    .clk(clk), .reset(reset), .ena(ena),
    .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc),
    .load_acc(load_acc), .load_ir(load_ir),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena),
    .halt(halt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
  endtask

  // Model state: position in instruction cycle and halted flag.
  int m_pos = 0;
  bit m_halted = 0;
  bit [7:0] m_out = '0;

  function automatic bit [7:0] expect_row(int p, int op, bit z);
    bit alu, i, lp, la, li, r, w, d, h;
    alu = (op >= 2) && (op <= 5);
    li  = (p <= 1);
    r   = (p <= 1) || (alu && p >= 4 && p <= 6);
    i   = (p == 1) || (p == 3 && op != 0)
       || (p == 5 && ((op == 1 && z) || op == 7))
       || (p == 7 && op == 1 && z);
    lp  = (op == 7) && (p == 4 || p == 5);
    la  = alu && (p == 5);
    d   = (op == 6) && (p >= 4 && p <= 6);
    w   = (op == 6) && (p == 5);
    h   = (op == 0) && (p == 3);
    return {i, lp, la, li, r, w, d, h};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos = 0; m_halted = 0; m_out = '0;
    end else if (m_halted) begin
      m_pos = 4; m_out = 8'b0000_0001;
    end else if (!ena) begin
      m_pos = 0; m_out = '0;
    end else begin
      m_out = expect_row(m_pos, int'(opcode), zero);
      if (m_out[0]) m_halted = 1;
      m_pos = (m_pos + 1) % 8;
    end
  end

  always @(negedge clk) begin
    check("outs", {inc_pc, load_pc, load_acc, load_ir,
                   rd, wr, datactl_ena, halt}, m_out);
    check("state", {5'd0, state}, 8'(m_pos));
    check("rd_wr_excl", {7'd0, rd & wr}, 8'd0);
    check("wr_dctl", {7'd0, wr & ~datactl_ena}, 8'd0);
  end

  logic [8:1] h_rd, h_wr, h_inc, h_lpc, h_lacc, h_ir, h_dctl, h_halt;

  task automatic run_cycle(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      h_rd[e] = rd;     h_wr[e] = wr;
      h_inc[e] = inc_pc; h_lpc[e] = load_pc;
      h_lacc[e] = load_acc; h_ir[e] = load_ir;
      h_dctl[e] = datactl_ena; h_halt[e] = halt;
    end
  endtask

  initial begin
    reset = 1'b0; ena = 1'b0; opcode = 3'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {5'd0, state}, 8'd0);
    check("rst_halt", {7'd0, halt}, 8'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_state", {5'd0, state}, 8'd0);
    check("idle_rd", {7'd0, rd}, 8'd0);

    ena = 1'b1;
    run_cycle(3'd5, 1'b0);
    check("start_e1", {6'd0, h_rd[1], h_ir[1]}, 8'b11);
    check("start_inc", {6'd0, h_inc[2], h_inc[1]}, 8'b10);
    check("lda_rd", h_rd, 8'b0111_0011);
    check("lda_lacc", h_lacc, 8'b0010_0000);
    check("lda_inc", h_inc, 8'b0000_1010);
    check("lda_wr_lpc_h", h_wr | h_lpc | h_halt, 8'd0);

    run_cycle(3'd6, 1'b0);
    check("sto_dctl", h_dctl, 8'b0111_0000);
    check("sto_wr", h_wr, 8'b0010_0000);
    check("sto_rd", h_rd, 8'b0000_0011);

    run_cycle(3'd1, 1'b1);
    check("skz1_inc", h_inc, 8'b1010_1010);
    run_cycle(3'd1, 1'b0);
    check("skz0_inc", h_inc, 8'b0000_1010);

    run_cycle(3'd7, 1'b0);
    check("jmp_lpc", h_lpc, 8'b0011_0000);

    run_cycle(3'd0, 1'b0);
    check("hlt_halt", h_halt, 8'b1111_1000);
    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 0) ena = ~ena;
      @(posedge clk);
      @(negedge clk);
      if (k == 19) begin
        check("hold_state", {5'd0, state}, 8'd4);
        check("hold_halt", {7'd0, halt}, 8'd1);
      end
    end

    #2 reset = 1'b0;
    #1;
    check("async_halt", {7'd0, halt}, 8'd0);
    check("async_state", {5'd0, state}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    ena = 1'b1;
    opcode = 3'd5;
    @(posedge clk);
    @(negedge clk);
    check("rel_s0", {6'd0, rd, load_ir}, 8'b11);
    check("rel_state", {5'd0, state}, 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
